mem_bus_ctrl: RTL

- MEM-stage memory access controller.
- Consumes the memory op, address and store data produced by the EX stage, checks word alignment, and drives the shared bus as a master using a req/grant and address-strobe/ready handshake.
- Returns load data or the passthrough ALU result to the MEM/WB path.
- Raises busy to stall the pipeline for the duration of a bus access.

---
 rtl/mem_bus_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/mem_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mem_bus_ctrl
//  Desc     : MEM-stage memory access controller. Checks word alignment of
//             loads/stores, masters the shared bus with a req/grant and
//             address-strobe/ready handshake, returns load data or the ALU
//             passthrough, and stalls the pipeline during a bus access.
//             Optional ACCESS watchdog enabled by macro MEM_BUS_TIMEOUT_EN.
//  Revision : 1.0  initial release
// ============================================================================
module mem_bus_ctrl #(
  parameter int ADDR_W         = 30,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mem_op,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              stall,
  input  logic              flush,
  output logic [DATA_W-1:0] out,
  output logic              miss_align,
  output logic              busy,
  output logic              bus_req,
  input  logic              bus_grant,
  output logic              bus_as_,
  output logic              bus_rw,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wr_data,
  input  logic [DATA_W-1:0] bus_rd_data,
  input  logic              bus_rdy_,
  output logic              bus_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACCESS = 2'd2,
    STALL  = 2'd3
  } state_t;

  localparam logic [1:0] c_op_load  = 2'b01;
  localparam logic [1:0] c_op_store = 2'b10;

  state_t              r_state;
  state_t              w_next_state;
  logic [DATA_W-1:0]   r_rd_buf;
  logic                w_is_mem;
  logic                w_is_load;
  logic                w_unaligned;
  logic                w_launch;
  logic                w_timeout;

  assign w_is_mem    = (mem_op == c_op_load) || (mem_op == c_op_store);
  assign w_is_load   = (mem_op == c_op_load);
  assign w_unaligned = (addr[1:0] != 2'b00);
  assign w_launch    = w_is_mem && !w_unaligned && !flush;
  assign miss_align  = w_is_mem && w_unaligned && (r_state == IDLE);

`ifdef MEM_BUS_TIMEOUT_EN
  localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);
  logic [c_cnt_w-1:0] r_to_cnt;

  // Expiry on the last permitted waiting cycle of ACCESS.
  assign w_timeout = (r_state == ACCESS) && bus_rdy_ &&
                     (r_to_cnt == c_cnt_w'(TIMEOUT_CYCLES - 1));

  // Watchdog counter: cleared entering ACCESS, counts cycles waiting on ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_to_cnt <= '0;
    end else if (r_state == REQ) begin
      r_to_cnt <= '0;
    end else if ((r_state == ACCESS) && bus_rdy_) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
  assign w_timeout        = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic plus combinational out/busy.
  always_comb begin
    w_next_state = r_state;
    out          = '0;
    busy         = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_is_mem) begin
          out = addr[DATA_W-1:0];
        end else if (w_launch) begin
          busy         = 1'b1;
          w_next_state = REQ;
        end
      end
      REQ: begin
        busy = 1'b1;
        if (flush)          w_next_state = IDLE;
        else if (bus_grant) w_next_state = ACCESS;
      end
      ACCESS: begin
        if (!bus_rdy_) begin
          out          = bus_rw ? bus_rd_data : '0;
          w_next_state = stall ? STALL : IDLE;
        end else if (w_timeout) begin
          w_next_state = IDLE;
        end else begin
          busy = 1'b1;
        end
      end
      STALL: begin
        out = r_rd_buf;
        if (!stall) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Registered bus master signals and load-data buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus_req     <= 1'b0;
      bus_as_     <= 1'b1;
      bus_rw      <= 1'b1;
      bus_addr    <= '0;
      bus_wr_data <= '0;
      r_rd_buf    <= '0;
      bus_err     <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_launch) bus_req <= 1'b1;
        end
        REQ: begin
          if (flush) begin
            bus_req <= 1'b0;
          end else if (bus_grant) begin
            bus_as_     <= 1'b0;
            bus_addr    <= addr[ADDR_W+1:2];
            bus_rw      <= w_is_load;
            bus_wr_data <= wr_data;
          end
        end
        ACCESS: begin
          if (!bus_rdy_) begin
            r_rd_buf <= bus_rd_data;
            bus_as_  <= 1'b1;
            bus_req  <= 1'b0;
          end else if (w_timeout) begin
            bus_as_  <= 1'b1;
            bus_req  <= 1'b0;
            bus_err  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
